// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one external combinational alu32 among NREQ requesters.
// Optional performance counters (op_count, stall_count) are enabled by `define ALU_SHARE_ARBITER_PERF_EN.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0]  req_op,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [31:0]        alu_result,
  input  logic [3:0]         alu_flags,
`ifdef ALU_SHARE_ARBITER_PERF_EN
  output logic [31:0]        op_count,
  output logic [31:0]        stall_count,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] grant_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [NREQ-1:0]  rsp_valid_reg;
  logic [31:0]      rsp_result_reg;
  logic [3:0]       rsp_flags_reg;
  logic [31:0]      op_a_reg;
  logic [31:0]      op_b_reg;
  logic [2:0]       op_ctrl_reg;

  logic [31:0] lane_a  [NREQ];
  logic [31:0] lane_b  [NREQ];
  logic [2:0]  lane_op [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_a[gi]  = req_a[32*gi +: 32];
      assign lane_b[gi]  = req_b[32*gi +: 32];
      assign lane_op[gi] = req_op[3*gi +: 3];
    end
  endgenerate

  // Walk the lanes from the farthest rotated offset back to ptr so the nearest valid lane wins.
  logic [PTR_W-1:0] pick;
  logic [PTR_W:0]   cand;
  logic             req_any;

  always_comb begin
    pick = ptr_reg;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (req_valid[cand[PTR_W-1:0]]) begin
        pick = cand[PTR_W-1:0];
      end
    end
  end

  assign req_any = |req_valid;

  always_comb begin
    req_ready = '0;
    if (!rst && state_reg == IDLE && req_any) begin
      req_ready[pick] = 1'b1;
    end
  end

  assign ptr_next = (grant_reg == PTR_W'(NREQ - 1)) ? '0 : grant_reg + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      grant_reg      <= '0;
      rsp_valid_reg  <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_ctrl_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            op_a_reg    <= lane_a[pick];
            op_b_reg    <= lane_b[pick];
            op_ctrl_reg <= lane_op[pick];
            grant_reg   <= pick;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg           <= alu_result;
          rsp_flags_reg            <= alu_flags;
          rsp_valid_reg[grant_reg] <= 1'b1;
          state_reg                <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_reg]) begin
            rsp_valid_reg <= '0;
            ptr_reg       <= ptr_next;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The ALU operand registers double as the alu_* outputs and hold outside EXEC.
  assign alu_a      = op_a_reg;
  assign alu_b      = op_b_reg;
  assign alu_ctrl   = op_ctrl_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_flags  = rsp_flags_reg;
  assign busy       = (state_reg != IDLE);

`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic [31:0] op_count_reg;
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg    <= '0;
      stall_count_reg <= '0;
    end else if (state_reg == RESP) begin
      if (rsp_ready[grant_reg]) begin
        op_count_reg <= op_count_reg + 32'd1;
      end else begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign op_count    = op_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Time-shares one combinational alu32 instance (ops 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 Mean, 6 Min, 7 ReLU; flags {N,Z,C,V}) between NREQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes, registered operands and results.
- Sits between the pipeline clients and the ALU; the ALU itself is instantiated outside and wired to the alu_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTR_W, 2, width of round-robin pointer/grant index; must be at least clog2(NREQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  32*NREQ  operand a, requester i at bits [32i+31:32i].
- req_b  input  32*NREQ  operand b, same packing.
- req_op  input  3*NREQ  ALUControl code, requester i at [3i+2:3i].
- rsp_valid  output  NREQ  per-requester result valid; one-hot or zero.
- rsp_ready  input  NREQ  per-requester result accept.
- rsp_result  output  32  result for the requester flagged in rsp_valid.
- rsp_flags  output  4  ALUFlags for that result.
- alu_a  output  32  to alu32 a.
- alu_b  output  32  to alu32 b.
- alu_ctrl  output  3  to alu32 ALUControl.
- alu_result  input  32  from alu32 Result.
- alu_flags  input  4  from alu32 ALUFlags.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - state=IDLE, ptr=0, grant=0.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0.
  - alu_a=0, alu_b=0, alu_ctrl=0, busy=0.
  - Any in-flight operation is dropped without a response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes in that cycle.
  - a, b and op of requester g are registered into op_a/op_b/op_ctrl; grant<=g; go to EXEC.
  - No valid request: stay in IDLE, req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl are driven from the registered operands. They are registered outputs and hold their value in all other states.
  - At the clock edge, alu_result/alu_flags are captured into rsp_result/rsp_flags.
  - rsp_valid[grant]<=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[grant], rsp_result and rsp_flags are held stable until rsp_ready[grant]=1.
  - On that edge: rsp_valid<=0, ptr<=(grant+1) mod NREQ, go to IDLE.
  - rsp_ready on non-granted lanes is ignored.
- Latency and throughput:
  - Request accepted in cycle t; rsp_valid rises in cycle t+2.
  - Minimum issue interval is 3 cycles (accept, exec, response taken).
- Fairness:
  - The requester just served has lowest priority next time.
  - All NREQ continuously valid: grants go 0,1,2,…,NREQ-1,0.
- Boundary conditions:
  - req_valid deasserted while not granted: no effect.
  - Operands of a non-granted requester may change freely.
  - Operands of the granted requester may change after its handshake cycle.
  - New requests arriving during EXEC/RESP wait; req_ready stays 0.
- Result and flags are passed through bit-exact; no width change.
- ptr never points at or beyond NREQ.

Optional Feature:
- Macro ALU_SHARE_ARBITER_PERF_EN.
- Defined:
  - Adds output op_count (32 bits), incremented on each completed response handshake. Wraps 0xFFFFFFFF->0.
  - Adds output stall_count (32 bits), incremented each cycle in RESP with rsp_ready[grant]=0.
  - Both counters clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, state IDLE; req_valid=0 for 5 cycles -> req_ready stays 0, busy 0.
- Single ADD, req 0: a=1, b=FFFFFFFF, op=0, rsp_ready=1 -> req_ready[0] in cycle t, rsp_valid[0] in t+2, rsp_result=0, rsp_flags=4'd6.
- Backpressure, req 1: SUB a=00000100, b=1, rsp_ready[1]=0 for 4 cycles:
  - Result 000000FF, flags 0, held stable; busy=1; req 0 valid meanwhile gets no ready.
  - After rsp_ready[1]=1, req 0 is granted next.
- Round-robin, NREQ=4, all valid:
  - req i op=5 (Mean), a=11111111, b=1.
  - Grants 0,1,2,3,0 in order; each rsp_result=08888889, flags 0.
- Reset mid-op: assert rst during EXEC of Min(0,1) -> no rsp_valid ever; ptr=0; next request from req 2 is served normally (ReLU a=FFFFFFFF -> 0, flags 4'd4).
- With ALU_SHARE_ARBITER_PERF_EN: 3 completed ops plus 4 stalled RESP cycles -> op_count=3, stall_count=4; rst clears both to 0.
